// File: rtl/picomips_sequencer.sv
// picoMips multi-cycle sequencer: FETCH/DECODE/EXEC/WB FSM, PC, strobes, HEI wait on debounced SW8.
// Optional single-step mode (step_raw port) is enabled by defining PICOMIPS_SINGLE_STEP_EN.

package picomips_opcodes_pkg;
    localparam int unsigned FUNC_W = 3;
    localparam int unsigned PHASE_W = 2;

    // Opcode encodings of instruction[7:5], as defined in opcodes.sv.
    localparam logic [FUNC_W-1:0] OP_ADD  = 3'b000;
    localparam logic [FUNC_W-1:0] OP_ADDI = 3'b001;
    localparam logic [FUNC_W-1:0] OP_MULI = 3'b010;
    localparam logic [FUNC_W-1:0] OP_ATR  = 3'b011;
    localparam logic [FUNC_W-1:0] OP_HEI  = 3'b100;
endpackage

module picomips_sequencer
    import picomips_opcodes_pkg::*;
#(
    parameter int unsigned PC_W       = 5,
    parameter int unsigned PROG_LEN   = 24,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned DEB_W      = 20
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic               sw8_raw,
`ifdef PICOMIPS_SINGLE_STEP_EN
    input  logic               step_raw,
`endif
    input  logic [FUNC_W-1:0]  func,
    input  logic               hei_arg,
    output logic [PC_W-1:0]    pc,
    output logic               fetch_en,
    output logic               reg_rd_en,
    output logic               acc_we,
    output logic               reg_we,
    output logic [PHASE_W-1:0] phase,
    output logic               waiting,
    output logic               sw8_db
);

    typedef enum logic [PHASE_W-1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             fetch_nxt;
    logic             rd_nxt;
    logic             acc_nxt;
    logic             regwe_nxt;
    logic             hei_hold_c;
    logic             run_c;
    logic             sw8_meta;
    logic             sw8_sync;
    logic [DEB_W-1:0] deb_cnt;

    // SW8 conditioning: two-flop synchroniser followed by a stability counter.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sw8_meta <= 1'b0;
            sw8_sync <= 1'b0;
            deb_cnt  <= '0;
            sw8_db   <= 1'b0;
        end else begin
            sw8_meta <= sw8_raw;
            sw8_sync <= sw8_meta;
            if (sw8_sync == sw8_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                sw8_db  <= ~sw8_db;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

`ifdef PICOMIPS_SINGLE_STEP_EN
    localparam logic FREE_RUN = 1'b0;

    logic step_meta;
    logic step_sync;
    logic step_prev;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_meta <= step_raw;
            step_sync <= step_meta;
            step_prev <= step_sync;
        end
    end

    // One pulse per rising edge; only honoured while parked in FETCH.
    assign run_c = step_sync & ~step_prev;
`else
    localparam logic FREE_RUN = 1'b1;

    assign run_c = 1'b1;
`endif

    assign hei_hold_c = (func == OP_HEI) && (sw8_db == hei_arg);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // FETCH with fetch_en low is the parked state (after reset, or between single steps).
    always_comb begin
        state_nxt = state;
        fetch_nxt = 1'b0;
        rd_nxt    = 1'b0;
        acc_nxt   = 1'b0;
        regwe_nxt = 1'b0;
        case (state)
            S_FETCH: begin
                if (fetch_en) begin
                    state_nxt = S_DECODE;
                    rd_nxt    = 1'b1;
                end else if (run_c) begin
                    fetch_nxt = 1'b1;
                end
            end
            S_DECODE: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (!hei_hold_c) begin
                    state_nxt = S_WB;
                    acc_nxt   = (func != OP_HEI) && (func != OP_ATR);
                    regwe_nxt = (func == OP_ATR);
                end
            end
            S_WB: begin
                state_nxt = S_FETCH;
                fetch_nxt = FREE_RUN;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            fetch_en  <= 1'b0;
            reg_rd_en <= 1'b0;
            acc_we    <= 1'b0;
            reg_we    <= 1'b0;
        end else begin
            fetch_en  <= fetch_nxt;
            reg_rd_en <= rd_nxt;
            acc_we    <= acc_nxt;
            reg_we    <= regwe_nxt;
        end
    end

    // PC advances only as WB retires, wrapping after the last instruction.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc <= '0;
        end else if (state == S_WB) begin
            if (pc == PC_W'(PROG_LEN - 1)) begin
                pc <= '0;
            end else begin
                pc <= pc + PC_W'(1);
            end
        end
    end

    assign phase   = state;
    assign waiting = (state == S_EXEC) && hei_hold_c;

endmodule

// File: tb/tb_picomips_sequencer.sv
// Scoreboard bench for picomips_sequencer: per-instruction WB expectations plus directed timing checks.
module tb_picomips_sequencer;
    import picomips_opcodes_pkg::*;

    localparam int unsigned PC_W       = 5;
    localparam int unsigned PROG_LEN   = 24;
    localparam int unsigned DEB_CYCLES = 4;
    localparam int unsigned DEB_W      = 20;

    logic              Clock   = 1'b0;
    logic              nReset  = 1'b0;
    logic              sw8_raw = 1'b0;
    logic [FUNC_W-1:0] func    = '0;
    logic              hei_arg = 1'b0;
`ifdef PICOMIPS_SINGLE_STEP_EN
    logic              step_raw = 1'b0;
`endif
    logic [PC_W-1:0]    pc;
    logic               fetch_en;
    logic               reg_rd_en;
    logic               acc_we;
    logic               reg_we;
    logic [PHASE_W-1:0] phase;
    logic               waiting;
    logic               sw8_db;

    picomips_sequencer #(
        .PC_W(PC_W), .PROG_LEN(PROG_LEN), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)
    ) dut (
        .Clock(Clock),
        .nReset(nReset),
        .sw8_raw(sw8_raw),
`ifdef PICOMIPS_SINGLE_STEP_EN
        .step_raw(step_raw),
`endif
        .func(func),
        .hei_arg(hei_arg),
        .pc(pc),
        .fetch_en(fetch_en),
        .reg_rd_en(reg_rd_en),
        .acc_we(acc_we),
        .reg_we(reg_we),
        .phase(phase),
        .waiting(waiting),
        .sw8_db(sw8_db)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            acc;
        logic            rw;
    } wb_exp_t;

    wb_exp_t           sb[$];
    logic [FUNC_W-1:0] prog_func [PROG_LEN];
    logic              prog_arg  [PROG_LEN];
    int                n_vec  = 0;
    int                n_miss = 0;
    int unsigned       exp_pc = 0;
    bit                mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_phase_pc(input logic [1:0] ph, input logic [PC_W-1:0] p, input int budget);
        int n = 0;
        while (!(phase == ph && pc == p) && n < budget) begin
            @(negedge Clock);
            n++;
        end
        check("wait_phase_pc", 32'(phase == ph && pc == p), 32'd1);
    endtask

    // Program memory + scoreboard: push on fetch, pop and compare in WB.
    always @(negedge Clock) begin
        wb_exp_t           e;
        logic [FUNC_W-1:0] f;
        if (nReset && mon_en) begin
            check("strobe_excl", 32'($countones({fetch_en, reg_rd_en, acc_we, reg_we}) <= 1), 32'd1);
            if (phase != 2'd3) check("we_outside_wb", 32'({acc_we, reg_we}), 32'd0);
            if (fetch_en) begin
                check("fetch_pc", 32'(pc), 32'(exp_pc));
                f       = prog_func[exp_pc];
                func    = f;
                hei_arg = prog_arg[exp_pc];
                sb.push_back('{pc: PC_W'(exp_pc), acc: (f != OP_HEI && f != OP_ATR), rw: (f == OP_ATR)});
                exp_pc = (exp_pc + 1) % PROG_LEN;
            end
            if (phase == 2'd3) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("wb_pc", 32'(pc), 32'(e.pc));
                    check("wb_acc_we", 32'(acc_we), 32'(e.acc));
                    check("wb_reg_we", 32'(reg_we), 32'(e.rw));
                end
            end
        end
    end

    initial begin
        #200000;
        check("watchdog", 32'd0, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        int n;
        for (int i = 0; i < int'(PROG_LEN); i++) begin
            prog_func[i] = OP_ADDI;
            prog_arg[i]  = 1'b0;
        end
        prog_func[3]  = OP_ADD;
        prog_func[4]  = 3'b111;
        prog_func[5]  = OP_ATR;
        prog_func[7]  = OP_HEI;
        prog_func[9]  = OP_MULI;
        prog_func[12] = OP_HEI;

        // Reset with SW8 held high: conditioning must stay cleared.
        nReset  = 1'b0;
        sw8_raw = 1'b1;
        repeat (3) @(negedge Clock);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_fetch_en", 32'(fetch_en), 32'd0);
        check("rst_strobes", 32'({reg_rd_en, acc_we, reg_we}), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_waiting", 32'(waiting), 32'd0);
        check("rst_sw8_db", 32'(sw8_db), 32'd0);
        sw8_raw = 1'b0;
        nReset  = 1'b1;
        mon_en  = 1'b1;

`ifdef PICOMIPS_SINGLE_STEP_EN
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            check("park_pc", 32'(pc), 32'd0);
            check("park_fetch_en", 32'(fetch_en), 32'd0);
            check("park_phase", 32'(phase), 32'd0);
        end
        step_raw = 1'b1;
        repeat (3) @(negedge Clock);
        step_raw = 1'b0;
        wait_phase_pc(2'd3, PC_W'(0), 20);
        for (int c = 0; c < 15; c++) begin
            @(negedge Clock);
            check("step_park_pc", 32'(pc), 32'd1);
            check("step_park_fetch_en", 32'(fetch_en), 32'd0);
            check("step_park_phase", 32'(phase), 32'd0);
        end
`else
        // First three ALU instructions: fetch at 0,4,8 and acc_we at 3,7,11.
        for (int k = 0; k < 12; k++) begin
            @(negedge Clock);
            check("t_fetch_en", 32'(fetch_en), 32'(k % 4 == 0));
            check("t_reg_rd_en", 32'(reg_rd_en), 32'(k % 4 == 1));
            check("t_acc_we", 32'(acc_we), 32'(k % 4 == 3));
            check("t_reg_we", 32'(reg_we), 32'd0);
            check("t_pc", 32'(pc), 32'(k / 4));
        end

        wait_phase_pc(2'd3, PC_W'(5), 40);
        check("atr_reg_we", 32'(reg_we), 32'd1);
        check("atr_acc_we", 32'(acc_we), 32'd0);
        @(negedge Clock);
        check("atr_pc_next", 32'(pc), 32'd6);

        // HEI wait with a short glitch that must be filtered out.
        wait_phase_pc(2'd2, PC_W'(7), 20);
        check("hei_waiting_entry", 32'(waiting), 32'd1);
        for (int c = 0; c < 50; c++) begin
            if (c == 20) sw8_raw = 1'b1;
            if (c == 22) sw8_raw = 1'b0;
            @(negedge Clock);
            check("hei_waiting", 32'(waiting), 32'd1);
            check("hei_pc", 32'(pc), 32'd7);
            check("hei_strobes", 32'({fetch_en, reg_rd_en, acc_we, reg_we}), 32'd0);
            check("hei_sw8_db", 32'(sw8_db), 32'd0);
        end
        sw8_raw = 1'b1;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (phase != 2'd3 && n < 20);
        check("hei_exit_latency", 32'(n), 32'(2 + DEB_CYCLES + 1));
        check("hei_wb_acc_we", 32'(acc_we), 32'd0);
        check("hei_sw8_db_high", 32'(sw8_db), 32'd1);

        wait_phase_pc(2'd3, PC_W'(PROG_LEN - 1), 300);
        sw8_raw = 1'b0;
        @(negedge Clock);
        check("wrap_pc", 32'(pc), 32'd0);
        check("wrap_fetch_en", 32'(fetch_en), 32'd1);
        check("wrap_phase", 32'(phase), 32'd0);

        // Asynchronous reset in the middle of an HEI wait.
        wait_phase_pc(2'd2, PC_W'(7), 100);
        repeat (5) @(negedge Clock);
        check("pre_rst_waiting", 32'(waiting), 32'd1);
        #2;
        nReset = 1'b0;
        mon_en = 1'b0;
        #1;
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_waiting", 32'(waiting), 32'd0);
        check("arst_phase", 32'(phase), 32'd0);
        sb.delete();
        exp_pc = 0;
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        mon_en = 1'b1;
        @(negedge Clock);
        check("rel_fetch_en", 32'(fetch_en), 32'd1);
        check("rel_phase", 32'(phase), 32'd0);
        check("rel_pc", 32'(pc), 32'd0);
        @(negedge Clock);
        check("rel_decode", 32'(phase), 32'd1);
        check("rel_reg_rd_en", 32'(reg_rd_en), 32'd1);
        wait_phase_pc(2'd3, PC_W'(2), 40);
`endif
        @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
